// File: rtl/parallel_load_sequencer_if.sv
// Word-stream, frame-ready and register-bank write bus of the parallel load sequencer.
// Latency: none, signal bundle only.
// Backpressure: recv_val/recv_rdy and send_val/send_rdy handshakes; a transfer needs both high at a clock edge.
// Ports: recv_* producer word stream, send_* frame-ready handshake,
//        wr_* bank write strobe/select/data, count = registers filled.
interface parallel_load_sequencer_if #(
    parameter int N   = 32,
    parameter int dib = 1
);
    localparam int NREG = 1 << dib;

    logic            recv_val;
    logic            recv_rdy;
    logic [N-1:0]    recv_msg;
    logic            send_val;
    logic            send_rdy;
    logic [NREG-1:0] wr_en;
    logic [dib-1:0]  wr_sel;
    logic [N-1:0]    wr_data;
    logic [dib:0]    count;

    // Sequencer side.
    modport slave (
        input  recv_val, recv_msg, send_rdy,
        output recv_rdy, send_val, wr_en, wr_sel, wr_data, count
    );

    // Producer / consumer / bank side.
    modport master (
        output recv_val, recv_msg, send_rdy,
        input  recv_rdy, send_val, wr_en, wr_sel, wr_data, count
    );
endinterface

// File: rtl/parallel_load_sequencer.sv
// Steers a val/rdy word stream into an NREG-register bank one-hot and flags full frames.
// Latency: write strobe combinational with the transfer; send_val rises the cycle after the NREG-th word.
// Backpressure: recv_rdy=1 while filling; while draining recv_rdy follows send_rdy, so fill and drain can overlap.
// Ports: clk, reset (async active-low), flush (sync abort), bus (slave modport of parallel_load_sequencer_if).
module parallel_load_sequencer #(
    parameter int dib = 1,
    parameter int N   = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    parallel_load_sequencer_if.slave bus
);
    localparam int NREG = 1 << dib;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [dib-1:0] idx_q, idx_d;

    logic            recv_rdy;
    logic            send_val;
    logic            recv_xfer;
    logic            send_xfer;
    logic [dib-1:0]  wr_sel;
    logic [dib:0]    count;
    logic [NREG-1:0] wr_en;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        recv_rdy = 1'b0;
        send_val = 1'b0;
        wr_sel   = '0;
        count    = '0;

        case (state_q)
            FILL: begin
                recv_rdy = 1'b1;
                wr_sel   = idx_q;
                count    = {1'b0, idx_q};
            end
            DRAIN: begin
                send_val = 1'b1;
                count    = (dib+1)'(NREG);
                // Accepting a word while the consumer takes the frame lets
                // register 0 be refilled on the same edge it is read.
                recv_rdy = bus.send_rdy;
            end
            default: ;
        endcase

        // Flush blocks both handshakes this cycle; the reset term keeps the
        // producer stalled for as long as reset is held.
        if (flush) begin
            recv_rdy = 1'b0;
            send_val = 1'b0;
        end
        if (!reset) begin
            recv_rdy = 1'b0;
        end

        recv_xfer = bus.recv_val && recv_rdy;
        send_xfer = send_val && bus.send_rdy;
        wr_en     = recv_xfer ? (NREG'(1) << wr_sel) : '0;

        if (flush) begin
            state_d = FILL;
            idx_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (recv_xfer) begin
                        if (idx_q == dib'(NREG - 1)) begin
                            idx_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            idx_d = idx_q + dib'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (send_xfer) begin
                        state_d = FILL;
                        idx_d   = recv_xfer ? dib'(1) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.recv_rdy = recv_rdy;
    assign bus.send_val = send_val;
    assign bus.wr_en    = wr_en;
    assign bus.wr_sel   = wr_sel;
    assign bus.wr_data  = bus.recv_msg;
    assign bus.count    = count;
endmodule

// File: tb/tb_parallel_load_sequencer.sv
module tb_parallel_load_sequencer;
    localparam int DIB  = 1;
    localparam int N    = 32;
    localparam int NREG = 1 << DIB;

    logic clk;
    logic reset;
    logic flush;
    int   tests;
    int   failed;

    logic [N-1:0] bank [NREG];

    parallel_load_sequencer_if #(.N(N), .dib(DIB)) bus ();

    parallel_load_sequencer #(.dib(DIB), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank driven by the sequencer's write strobes.
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (bus.wr_en[i]) bank[i] <= bus.wr_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after a rising edge; inputs are driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        reset        = 1'b0;
        flush        = 1'b0;
        bus.recv_val = 1'b1;
        bus.recv_msg = '0;
        bus.send_rdy = 1'b0;

        // Reset held for 3 cycles with a word offered.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_recv_rdy", 64'(bus.recv_rdy), 64'd0);
        chk("rst_send_val", 64'(bus.send_val), 64'd0);
        chk("rst_wr_en",    64'(bus.wr_en),    64'd0);
        chk("rst_count",    64'(bus.count),    64'd0);
        chk("rst_wr_sel",   64'(bus.wr_sel),   64'd0);
        reset        = 1'b1;
        bus.recv_val = 1'b0;
        tick();
        chk("post_rst_recv_rdy", 64'(bus.recv_rdy), 64'd1);

        // Basic frame with the consumer stalled.
        bus.recv_val = 1'b1;
        bus.recv_msg = 32'hAAAA0001;
        #1;
        chk("frame_wr_en0",  64'(bus.wr_en),   64'h1);
        chk("frame_wr_data", 64'(bus.wr_data), 64'hAAAA0001);
        tick();
        chk("frame_count1",  64'(bus.count),   64'd1);
        chk("frame_wr_sel1", 64'(bus.wr_sel),  64'd1);
        bus.recv_msg = 32'hBBBB0002;
        #1;
        chk("frame_wr_en1",  64'(bus.wr_en),   64'h2);
        tick();
        bus.recv_msg = 32'hDEADBEEF;
        #1;
        chk("drain_send_val", 64'(bus.send_val), 64'd1);
        chk("drain_count",    64'(bus.count),    64'd2);
        chk("drain_recv_rdy", 64'(bus.recv_rdy), 64'd0);
        chk("drain_wr_en",    64'(bus.wr_en),    64'd0);
        chk("bank0",          64'(bank[0]),      64'hAAAA0001);
        chk("bank1",          64'(bank[1]),      64'hBBBB0002);

        // Backpressure: ten stalled cycles in DRAIN.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_send_val", 64'(bus.send_val), 64'd1);
            chk("bp_wr_en",    64'(bus.wr_en),    64'd0);
            chk("bp_recv_rdy", 64'(bus.recv_rdy), 64'd0);
        end
        chk("bp_bank0", 64'(bank[0]), 64'hAAAA0001);
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b1;
        #1;
        chk("bp_release_send_val", 64'(bus.send_val), 64'd1);
        tick();
        bus.send_rdy = 1'b0;
        #1;
        chk("bp_fill_count",    64'(bus.count),    64'd0);
        chk("bp_fill_send_val", 64'(bus.send_val), 64'd0);
        chk("bp_fill_recv_rdy", 64'(bus.recv_rdy), 64'd1);

        // Refill, then overlap a new word with the frame handoff.
        bus.recv_val = 1'b1;
        bus.recv_msg = 32'h11111111;
        tick();
        bus.recv_msg = 32'h22222222;
        tick();
        chk("refill_send_val", 64'(bus.send_val), 64'd1);
        bus.send_rdy = 1'b1;
        bus.recv_msg = 32'h12345678;
        #1;
        chk("ovl_recv_rdy", 64'(bus.recv_rdy), 64'd1);
        chk("ovl_wr_en",    64'(bus.wr_en),    64'h1);
        tick();
        chk("ovl_count",    64'(bus.count),    64'd1);
        chk("ovl_wr_sel",   64'(bus.wr_sel),   64'd1);
        chk("ovl_send_val", 64'(bus.send_val), 64'd0);
        chk("ovl_bank0",    64'(bank[0]),      64'h12345678);
        chk("ovl_bank1",    64'(bank[1]),      64'h22222222);

        // Continuous streaming: one frame every two cycles.
        bus.recv_msg = 32'h00000009;
        #1;
        chk("stream_wr_en1", 64'(bus.wr_en), 64'h2);
        tick();
        chk("stream_send_val", 64'(bus.send_val), 64'd1);
        chk("stream_count2",   64'(bus.count),    64'd2);
        bus.recv_msg = 32'h0000000A;
        #1;
        chk("stream_wr_en0", 64'(bus.wr_en), 64'h1);
        tick();
        chk("stream_count1", 64'(bus.count), 64'd1);
        chk("stream_bank1",  64'(bank[1]),   64'h00000009);
        chk("stream_bank0",  64'(bank[0]),   64'h0000000A);

        // Flush a partial frame (count=1) while a word is offered.
        bus.send_rdy = 1'b0;
        flush        = 1'b1;
        bus.recv_msg = 32'h55555555;
        #1;
        chk("flush_wr_en",    64'(bus.wr_en),    64'd0);
        chk("flush_recv_rdy", 64'(bus.recv_rdy), 64'd0);
        tick();
        flush        = 1'b0;
        bus.recv_val = 1'b0;
        #1;
        chk("flush_count",  64'(bus.count),  64'd0);
        chk("flush_wr_sel", 64'(bus.wr_sel), 64'd0);
        chk("flush_bank0",  64'(bank[0]),    64'h0000000A);

        // Flush while draining drops the frame.
        bus.recv_val = 1'b1;
        bus.recv_msg = 32'h66666666;
        tick();
        bus.recv_msg = 32'h77777777;
        tick();
        bus.recv_val = 1'b0;
        #1;
        chk("pre_flush_send_val", 64'(bus.send_val), 64'd1);
        flush        = 1'b1;
        bus.send_rdy = 1'b1;
        #1;
        chk("dflush_send_val", 64'(bus.send_val), 64'd0);
        chk("dflush_wr_en",    64'(bus.wr_en),    64'd0);
        tick();
        flush        = 1'b0;
        bus.send_rdy = 1'b0;
        #1;
        chk("dflush_count",    64'(bus.count),    64'd0);
        chk("dflush_recv_rdy", 64'(bus.recv_rdy), 64'd1);
        chk("dflush_send_val2",64'(bus.send_val), 64'd0);

        // Asynchronous reset between edges after one word.
        bus.recv_val = 1'b1;
        bus.recv_msg = 32'h88888888;
        tick();
        bus.recv_val = 1'b0;
        #1;
        chk("arst_pre_count", 64'(bus.count), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_count",    64'(bus.count),    64'd0);
        chk("arst_recv_rdy", 64'(bus.recv_rdy), 64'd0);
        chk("arst_wr_sel",   64'(bus.wr_sel),   64'd0);
        chk("arst_send_val", 64'(bus.send_val), 64'd0);
        tick();
        reset        = 1'b1;
        bus.recv_val = 1'b1;
        bus.recv_msg = 32'h99999999;
        #1;
        chk("arst_first_wr_en", 64'(bus.wr_en), 64'h1);
        tick();
        chk("arst_bank0", 64'(bank[0]), 64'h99999999);
        chk("arst_count1", 64'(bus.count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
